// File: rtl/score2digits.sv
// score2digits: serial 14-bit binary to 4-digit BCD converter (double dabble),
// one iteration per clock, with a committed digit register and a registered
// digit read port selected by digit_sel.
// Optional feature: define SCORE2DIGITS_LZB_EN to blank leading zeros
// (thousands/hundreds/tens) with 4'hF at commit time.
module score2digits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    input  logic [1:0]  digit_sel,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [3:0]  digit
);

    localparam int unsigned BIN_W = 14;
    localparam int unsigned BCD_W = 16;
    localparam int unsigned CNT_W = 4;
    localparam logic [BIN_W-1:0] MAX_VAL   = BIN_W'(9999);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [3:0]         digit_q, digit_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       bcd_shift;
    logic [BIN_W-1:0]       bin_shift;
    logic [BCD_W-1:0]       commit_val;

    // One double-dabble step: add 3 to any nibble >= 5, then shift {bcd, bin} left
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 4; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                          : bcd_q[4*i +: 4];
        end
        shifted   = {bcd_adj, bin_q} << 1;
        bcd_shift = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_shift = shifted[BIN_W-1:0];
    end

`ifdef SCORE2DIGITS_LZB_EN
    logic th_blank, hu_blank, te_blank;

    // Replace zeros above the most significant nonzero digit with blank (4'hF); units always shown
    always_comb begin
        th_blank   = (bcd_shift[15:12] == 4'd0);
        hu_blank   = th_blank && (bcd_shift[11:8] == 4'd0);
        te_blank   = hu_blank && (bcd_shift[7:4] == 4'd0);
        commit_val = {th_blank ? 4'hF : bcd_shift[15:12],
                      hu_blank ? 4'hF : bcd_shift[11:8],
                      te_blank ? 4'hF : bcd_shift[7:4],
                      bcd_shift[3:0]};
    end
`else
    // Raw BCD result is committed as-is
    always_comb begin
        commit_val = bcd_shift;
    end
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    bin_d   = (value > MAX_VAL) ? MAX_VAL : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    dig_d   = commit_val;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (digit_sel)
            2'd0:    digit_d = dig_q[15:12];
            2'd1:    digit_d = dig_q[11:8];
            2'd2:    digit_d = dig_q[7:4];
            default: digit_d = dig_q[3:0];
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            digit_q <= 4'h0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            digit_q <= digit_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;
    assign digit = digit_q;

endmodule

// File: doc/score2digits.md
SCORE2DIGITS -- requirements
Module: score2digits

Interface
REQ-001 Parameter: none; value width fixed at 14 bits, 4 decimal digits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 value  input  14  unsigned binary number to convert, sampled only on an accepted load.
REQ-005 load  input  1  conversion request, single-cycle pulse or level.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when committed digits update.
REQ-008 valid  output  1  high once at least one conversion has completed since reset.
REQ-009 digit_sel  input  2  digit position: 0 = thousands, 1 = hundreds, 2 = tens, 3 = units.
REQ-010 digit  output  4  selected BCD digit, feeds numb2char input_numb; 4'hF means blank.

Function
REQ-011 FSM states SHALL be IDLE and SHIFT; reset state IDLE.
REQ-012 IDLE: load=1 at a rising edge SHALL be accepted: clamp value, clear BCD working register, clear iteration counter, go to SHIFT.
REQ-013 Clamp: value > 9999 SHALL be replaced by 9999 before conversion.
REQ-014 SHIFT SHALL perform one double-dabble iteration per cycle: each BCD nibble >= 5 gets +3, then shift {bcd, bin} left by 1.
REQ-015 Exactly 14 iterations SHALL occur, on the 14 rising edges following the accepting edge.
REQ-016 On the 14th iteration edge: the committed digit register SHALL load the final BCD result, and the FSM SHALL return to IDLE.
REQ-017 busy SHALL be high for exactly the 14 cycles between the accepting edge and the 14th iteration edge, low otherwise.
REQ-018 done SHALL be high for exactly the one cycle following the 14th iteration edge.
REQ-019 valid SHALL rise together with the first done and stay high until reset.
REQ-020 load while busy=1 SHALL be ignored; it is not queued.
REQ-021 load high in the done cycle SHALL be accepted, giving back-to-back conversions with 15-cycle spacing.
REQ-022 Committed digits SHALL change only on the 14th iteration edge; intermediate working values never reach digit.
REQ-023 digit SHALL be registered: the digit for digit_sel at edge N appears after edge N, one cycle latency, every cycle regardless of state.
REQ-024 Before the first completed conversion, digit SHALL output the reset committed value, 4'h0.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, busy 0, done 0, valid 0, digit 4'h0, committed digits all 4'h0, working register and counter 0.
REQ-026 Reset during SHIFT SHALL abandon the conversion with no commit and no done.
REQ-027 After rst_n deasserts, the first rising edge with load=1 SHALL be accepted normally.

Configuration
REQ-028 Macro SCORE2DIGITS_LZB_EN SHALL enable leading-zero blanking.
REQ-029 Defined: committed thousands/hundreds/tens digits that are zero and above the most significant nonzero digit SHALL be replaced by 4'hF at commit; units is never blanked. numb2char renders 4'hF as SPACE.
REQ-030 Undefined: all four committed digits SHALL be raw BCD 0-9, with no blanking logic present.

Verification
REQ-031 value=1234, load pulse: busy high 14 cycles, then done 1 cycle; sweeping digit_sel 0..3 gives 1,2,3,4 one cycle later.
REQ-032 value=10000, then value=16383: each gives digits 9,9,9,9; value=9999 gives the same.
REQ-033 value=0 and value=7: with the macro defined gives F,F,F,0 and F,F,F,7; with it undefined gives 0,0,0,0 and 0,0,0,7.
REQ-034 Convert 4321; then load 5678 during cycle 5 of busy: load ignored, digits 4,3,2,1, single done.
REQ-035 Convert 1111 to completion, start 2222, assert rst_n low at cycle 7: digit=0 and valid=0 immediately, no done; a fresh load of 42 after release gives 0,0,4,2 (macro undefined).
REQ-036 Hold load high continuously with value=555: done every 15 cycles, busy low exactly in each done cycle, digits 0,5,5,5 stable throughout.
